// File: rtl/reaction_pkg.sv
// Shared types for the reaction-time session sequencer.
package reaction_pkg;

    localparam int TW_DEFAULT = 14;

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        LIGHTS,
        MEASURE,
        RECORD,
        GAP,
        DONE,
        FALSE
    } state_t;

endpackage

// File: rtl/rise_detect.sv
// Rising-edge detector: a one-cycle pulse on the first cycle a level input is high.
module rise_detect (
    input  logic clk,
    input  logic rst,
    input  logic in,
    output logic pulse
);

    logic prev_q;
    logic prev_d;

    always_comb begin
        prev_d = in;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= prev_d;
        end
    end

    assign pulse = in & ~prev_q;

endmodule

// File: rtl/reaction_session_ctrl.sv
// Session sequencer for the reaction-time game: rounds, ms measurement, last/best times.
// Optional running sum output `sum_time` is built when REACT_SUM_EN is defined.
module reaction_session_ctrl
    import reaction_pkg::*;
#(
    parameter int ROUNDS     = 5,
    parameter int TW         = TW_DEFAULT,
    parameter int TIMEOUT_MS = 9999,
    parameter int GAP_MS     = 1000
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          tick_ms,
    input  logic          start_btn,
    input  logic          react_btn,
    input  logic          lights_out,
    output logic          lights_start,
    output logic          busy,
    output logic [2:0]    round_idx,
    output logic [TW-1:0] last_time,
    output logic [TW-1:0] best_time,
    output logic [TW-1:0] disp_value,
    output logic          false_start,
    output logic          timed_out,
`ifdef REACT_SUM_EN
    output logic [TW+2:0] sum_time,
`endif
    output logic          session_done
);

    localparam logic [TW-1:0] TIMEOUT_V  = TW'(TIMEOUT_MS);
    localparam logic [TW-1:0] GAP_V      = TW'(GAP_MS);
    localparam logic [2:0]    ROUND_LAST = 3'(ROUNDS - 1);

    logic start_edge;
    logic react_edge;

    rise_detect u_start_rise (
        .clk   (clk),
        .rst   (rst),
        .in    (start_btn),
        .pulse (start_edge)
    );

    rise_detect u_react_rise (
        .clk   (clk),
        .rst   (rst),
        .in    (react_btn),
        .pulse (react_edge)
    );

    state_t        state_q, state_d;
    logic [TW-1:0] cnt_q, cnt_d;
    logic [2:0]    round_q, round_d;
    logic [TW-1:0] last_q, last_d;
    logic [TW-1:0] best_q, best_d;
    logic          false_q, false_d;
    logic          timed_q, timed_d;
`ifdef REACT_SUM_EN
    localparam int SW = TW + 3;
    logic [SW-1:0] sum_q, sum_d;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        round_d = round_q;
        last_d  = last_q;
        best_d  = best_q;
        false_d = false_q;
        timed_d = timed_q;
`ifdef REACT_SUM_EN
        sum_d   = sum_q;
`endif
        case (state_q)
            IDLE, DONE, FALSE: begin
                if (start_edge) begin
                    state_d = ARM;
                    round_d = '0;
                    last_d  = '0;
                    best_d  = '1;
                    false_d = 1'b0;
                    timed_d = 1'b0;
`ifdef REACT_SUM_EN
                    sum_d   = '0;
`endif
                end
            end
            ARM: begin
                state_d = LIGHTS;
            end
            LIGHTS: begin
                // A press coinciding with lights-out is still a false start.
                if (react_edge) begin
                    state_d = FALSE;
                    false_d = 1'b1;
                end else if (lights_out) begin
                    state_d = MEASURE;
                    cnt_d   = '0;
                end
            end
            MEASURE: begin
                // The press wins over a same-cycle tick, so that tick is dropped.
                if (react_edge) begin
                    state_d = RECORD;
                end else if (tick_ms) begin
                    if (cnt_q >= TIMEOUT_V - 1'b1) begin
                        cnt_d   = TIMEOUT_V;
                        timed_d = 1'b1;
                        state_d = RECORD;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            RECORD: begin
                last_d = cnt_q;
                if (cnt_q < best_q) begin
                    best_d = cnt_q;
                end
`ifdef REACT_SUM_EN
                sum_d = sum_q + SW'(cnt_q);
`endif
                if (round_q == ROUND_LAST) begin
                    state_d = DONE;
                end else begin
                    round_d = round_q + 1'b1;
                    cnt_d   = '0;
                    state_d = GAP;
                end
            end
            GAP: begin
                if (tick_ms) begin
                    if (cnt_q >= GAP_V - 1'b1) begin
                        state_d = ARM;
                        timed_d = 1'b0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            round_q <= '0;
            last_q  <= '0;
            best_q  <= '1;
            false_q <= 1'b0;
            timed_q <= 1'b0;
`ifdef REACT_SUM_EN
            sum_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            round_q <= round_d;
            last_q  <= last_d;
            best_q  <= best_d;
            false_q <= false_d;
            timed_q <= timed_d;
`ifdef REACT_SUM_EN
            sum_q   <= sum_d;
`endif
        end
    end

    assign lights_start = (state_q == ARM);
    assign busy         = !((state_q == IDLE) || (state_q == DONE) || (state_q == FALSE));
    assign session_done = (state_q == DONE);
    assign round_idx    = round_q;
    assign last_time    = last_q;
    assign best_time    = best_q;
    assign false_start  = false_q;
    assign timed_out    = timed_q;
`ifdef REACT_SUM_EN
    assign sum_time     = sum_q;
`endif

    always_comb begin
        if (state_q == DONE) begin
            disp_value = best_q;
        end else if (state_q == FALSE) begin
            disp_value = '0;
        end else begin
            disp_value = last_q;
        end
    end

endmodule

// File: tb/tb_reaction_session_ctrl.sv
// Directed self-checking bench for reaction_session_ctrl (sum checks when REACT_SUM_EN is defined).
module tb_reaction_session_ctrl;

    localparam int TW = 14;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          tick_ms = 1'b0;
    logic          start_btn = 1'b0;
    logic          react_btn = 1'b0;
    logic          lights_out = 1'b0;
    logic          lights_start;
    logic          busy;
    logic [2:0]    round_idx;
    logic [TW-1:0] last_time;
    logic [TW-1:0] best_time;
    logic [TW-1:0] disp_value;
    logic          false_start;
    logic          timed_out;
    logic          session_done;
`ifdef REACT_SUM_EN
    logic [TW+2:0] sum_time;
`endif

    int n_checks = 0;
    int n_errors = 0;

    reaction_session_ctrl #(
        .ROUNDS     (5),
        .TW         (TW),
        .TIMEOUT_MS (9999),
        .GAP_MS     (1000)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .tick_ms      (tick_ms),
        .start_btn    (start_btn),
        .react_btn    (react_btn),
        .lights_out   (lights_out),
        .lights_start (lights_start),
        .busy         (busy),
        .round_idx    (round_idx),
        .last_time    (last_time),
        .best_time    (best_time),
        .disp_value   (disp_value),
        .false_start  (false_start),
        .timed_out    (timed_out),
`ifdef REACT_SUM_EN
        .sum_time     (sum_time),
`endif
        .session_done (session_done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick_n(input int n);
        repeat (n) begin
            tick_ms = 1'b1;
            step();
        end
        tick_ms = 1'b0;
    endtask

    task automatic pulse_lights_out();
        lights_out = 1'b1;
        step();
        lights_out = 1'b0;
    endtask

    task automatic press_start();
        start_btn = 1'b1;
        step();
        start_btn = 1'b0;
    endtask

    // Starts in LIGHTS; ends one cycle after RECORD with the result registered.
    task automatic do_round(input int t);
        pulse_lights_out();
        tick_n(t);
        react_btn = 1'b1;
        step();
        react_btn = 1'b0;
        step();
        $display("round: react after %0d ticks -> last=%0d best=%0d round_idx=%0d",
                 t, last_time, best_time, round_idx);
    endtask

    task automatic check_reset_values(input string pfx);
        check({pfx, "_lights_start"}, lights_start, 0);
        check({pfx, "_busy"}, busy, 0);
        check({pfx, "_round_idx"}, round_idx, 0);
        check({pfx, "_last_time"}, last_time, 0);
        check({pfx, "_best_time"}, best_time, 16383);
        check({pfx, "_disp_value"}, disp_value, 0);
        check({pfx, "_false_start"}, false_start, 0);
        check({pfx, "_timed_out"}, timed_out, 0);
        check({pfx, "_session_done"}, session_done, 0);
`ifdef REACT_SUM_EN
        check({pfx, "_sum_time"}, sum_time, 0);
`endif
    endtask

    int times [5] = '{300, 180, 220, 180, 400};
    int exp_best;

    initial begin
        repeat (3) step();
        rst = 1'b0;
        check_reset_values("reset");

        // Start held for two cycles: single ARM pulse, no retrigger.
        start_btn = 1'b1;
        step();
        check("arm_pulse", lights_start, 1);
        check("arm_busy", busy, 1);
        step();
        check("arm_pulse_end", lights_start, 0);
        start_btn = 1'b0;

        do_round(250);
        check("r1_last", last_time, 250);
        check("r1_best", best_time, 250);
        check("r1_round", round_idx, 1);
        check("r1_disp", disp_value, 250);

        // Button held through GAP and ARM must not count as a false start.
        react_btn = 1'b1;
        step();
        pulse_lights_out();
        tick_n(1000);
        check("gap_arm_pulse", lights_start, 1);
        step();
        step();
        check("held_no_false", false_start, 0);
        check("held_busy", busy, 1);
        react_btn = 1'b0;
        step();

        // Press coincident with the 100th tick: that tick is dropped.
        pulse_lights_out();
        tick_n(99);
        tick_ms = 1'b1;
        react_btn = 1'b1;
        step();
        tick_ms = 1'b0;
        react_btn = 1'b0;
        step();
        $display("round: react with 100th tick -> last=%0d", last_time);
        check("coinc_last", last_time, 99);
        check("coinc_best", best_time, 99);
        check("coinc_round", round_idx, 2);

        // Reset in the middle of round 3.
        tick_n(1000);
        step();
        pulse_lights_out();
        tick_n(50);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_reset_values("midrst");

        // Full five-round session.
        press_start();
        step();
        exp_best = 16383;
        for (int i = 0; i < 5; i++) begin
            do_round(times[i]);
            if (times[i] < exp_best) exp_best = times[i];
            check($sformatf("s_last%0d", i), last_time, times[i]);
            check($sformatf("s_best%0d", i), best_time, exp_best);
            check($sformatf("s_round%0d", i), round_idx, (i < 4) ? i + 1 : 4);
            if (i < 4) begin
                tick_n(1000);
                check($sformatf("s_arm%0d", i), lights_start, 1);
                step();
            end
        end
        check("done_flag", session_done, 1);
        check("done_best", best_time, 180);
        check("done_disp", disp_value, 180);
        check("done_busy", busy, 0);
`ifdef REACT_SUM_EN
        check("done_sum", sum_time, 1280);
`endif

        // New session from DONE, then false start during LIGHTS.
        press_start();
        check("new_arm_round", round_idx, 0);
        check("new_arm_best", best_time, 16383);
        check("new_arm_disp", disp_value, 0);
        check("new_arm_done", session_done, 0);
        step();
        react_btn = 1'b1;
        step();
        react_btn = 1'b0;
        $display("false start during lights: false_start=%0d disp=%0d", false_start, disp_value);
        check("fs_flag", false_start, 1);
        check("fs_disp", disp_value, 0);
        check("fs_busy", busy, 0);

        press_start();
        check("fs_rearm_pulse", lights_start, 1);
        check("fs_rearm_round", round_idx, 0);
        check("fs_rearm_flag", false_start, 0);
        step();

        // Press in the same cycle as lights-out.
        lights_out = 1'b1;
        react_btn = 1'b1;
        step();
        lights_out = 1'b0;
        react_btn = 1'b0;
        $display("false start with lights_out: false_start=%0d", false_start);
        check("fs2_flag", false_start, 1);
        check("fs2_busy", busy, 0);

        // Timeout saturation.
        press_start();
        step();
        pulse_lights_out();
        tick_n(10000);
        $display("timeout round: last=%0d timed_out=%0d", last_time, timed_out);
        check("to_last", last_time, 9999);
        check("to_flag", timed_out, 1);
        check("to_round", round_idx, 1);
        check("to_disp", disp_value, 9999);
        tick_n(1000);
        check("to_arm_pulse", lights_start, 1);
        check("to_arm_clear", timed_out, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/reaction_session_ctrl.md
# reaction_session_ctrl

Session sequencer for the F1 reaction-time game. Runs a fixed number of rounds back to back: fires the start-lights sequencer, waits for lights-out, measures the player's reaction in milliseconds, and flags false starts. It keeps the last and best times and drives the value shown on the BCD/7-segment path. It sits between the `clktick` ms tick, the lights FSM and `bin2bcd_16`, and replaces the free-running measurement counter.

## Interface
- `ROUNDS`, default 5: rounds per session, range 1–7.
- `TW`, default 14: width of time values in ms.
- `TIMEOUT_MS`, default 9999: saturation cap for a measured time.
- `GAP_MS`, default 1000: pause between rounds, in ms.

Ports (clock and reset first):
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous reset, active-high.
- `tick_ms`  in  1  one-cycle enable pulse, once per ms.
- `start_btn`  in  1  session start, active-high level, synchronous to `clk`.
- `react_btn`  in  1  player button, active-high level, synchronous to `clk`.
- `lights_out`  in  1  one-cycle pulse from the lights FSM when all lights extinguish.
- `lights_start`  out  1  one-cycle pulse that triggers the lights FSM.
- `busy`  out  1  high in every state except IDLE, DONE and FALSE.
- `round_idx`  out  3  current round, 0-based.
- `last_time`  out  TW  most recent recorded reaction.
- `best_time`  out  TW  minimum recorded reaction in this session.
- `disp_value`  out  TW  value for the BCD converter.
- `false_start`  out  1  sticky; set on a false start.
- `timed_out`  out  1  sticky per round; set when the last round saturated.
- `session_done`  out  1  high while in DONE.

## Operation
- `start_btn` and `react_btn` are rising-edge detected internally. Only edges act, so a held button never retriggers.
- States and transitions:
  - IDLE: on start edge → ARM, clear round/best/last/flags.
  - ARM: 1 cycle; `lights_start`=1 → LIGHTS.
  - LIGHTS: react edge → FALSE; `lights_out` → MEASURE with count=0.
  - MEASURE: `tick_ms` increments count. React edge → RECORD with count. Count reaching `TIMEOUT_MS` → RECORD with `TIMEOUT_MS` and `timed_out`=1.
  - RECORD: 1 cycle. `last_time`←value; `best_time`←value if strictly less. If `round_idx`==ROUNDS-1 → DONE, else `round_idx`+1 → GAP.
  - GAP: counts `GAP_MS` ticks → ARM. React edges are ignored.
  - DONE: start edge → ARM (new session, cleared as in IDLE).
  - FALSE: `false_start`=1, `round_idx` held. Start edge → ARM with everything cleared.
- `disp_value` = `best_time` in DONE, 0 in FALSE, `last_time` otherwise.
- `timed_out` clears on entry to ARM.
- Start edges in any busy state are ignored. `lights_out` outside LIGHTS is ignored.

## Timing
- Reset values:
  - state IDLE.
  - `lights_start`, `false_start`, `timed_out`, `session_done` = 0.
  - `round_idx` = 0, `last_time` = 0.
  - `best_time` = all ones (2^TW-1).
  - `disp_value` = 0.
- A reset asserted mid-session restores all of the above on the next edge. No partial results survive.
- Start edge at cycle n → ARM at n+1 → `lights_start` high at n+1 only.
- `lights_out` at cycle n → MEASURE at n+1. Ticks from n+1 onward are counted.
- React edge and `tick_ms` in the same MEASURE cycle: the edge wins and that tick is not counted.
- React edge and `lights_out` in the same LIGHTS cycle: false start.
- `last_time`/`best_time` update on the RECORD edge, i.e. 2 cycles after the react edge. `disp_value` follows combinationally from registers.
- Count saturates exactly at `TIMEOUT_MS`. There is no wrap. `TIMEOUT_MS` < 2^TW.

## Configuration
- `REACT_SUM_EN` defined:
  - Adds output `sum_time` [TW+2:0], the running sum of recorded times.
  - Reset value 0; cleared on entry to ARM from IDLE/DONE/FALSE; accumulated in RECORD.
- `REACT_SUM_EN` undefined: no port, no adder.

## Structure
- `reaction_pkg` holds the state enum typedef (`IDLE, ARM, LIGHTS, MEASURE, RECORD, GAP, DONE, FALSE`) and `TW_DEFAULT`.
- Sub-module `rise_detect` (clk, rst, in → 1-cycle pulse), instantiated twice.
- One ms counter, shared by MEASURE and GAP and cleared on state entry.

## Test plan
- Reset, then start edge: `lights_start` pulses exactly 1 cycle; after `lights_out` plus 250 ticks, react edge → `last_time`=250, `best_time`=250, `round_idx`=1.
- 5 rounds at 300/180/220/180/400 ms → DONE, `best_time`=180, `disp_value`=180, `session_done`=1; with `REACT_SUM_EN`, `sum_time`=1280.
- React edge during LIGHTS, or in the same cycle as `lights_out` → FALSE, `false_start`=1, `disp_value`=0; start edge → ARM with `round_idx`=0.
- No react for 10000 ticks → `last_time`=9999, `timed_out`=1; next ARM clears `timed_out`.
- React edge coincident with the 100th tick → 99 recorded. Held `react_btn` across GAP/ARM causes no false start.
- `rst` asserted in MEASURE round 3 → all outputs at reset values next cycle, state IDLE.
